// File: rtl/osd_tracesample_arbiter.sv
// ---------------------------------------------------------------------------------------------
// osd_tracesample_arbiter
//
// Purpose:
//   Shares one downstream trace packetizer/FIFO port between CHANNELS trace-sample streams.
//   Overflow records win over normal samples, so lost-sample counts drain first. Within each
//   class a single shared round-robin pointer picks the winner. The winning word is held in a
//   registered output stage tagged with its source channel and overflow flag.
//   A disabled channel is always drained (in_ready=1) and its word is dropped, so its
//   tracesample block never accumulates an overflow count.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_data         CHANNELS packed sample words, channel i at [i*WIDTH +: WIDTH]
//   in_overflow     per-channel overflow-record flag
//   in_valid        per-channel word present
//   in_ready        per-channel word consumed this cycle
//   enable          per-channel arbitration enable
//   out_data        registered winning word
//   out_overflow    registered overflow flag of the winning word
//   out_channel     registered index of the winning channel
//   out_valid       output register holds a word
//   out_ready       downstream accepts the word
// ---------------------------------------------------------------------------------------------
module osd_tracesample_arbiter #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned CHW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_overflow,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS-1:0]       enable,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_overflow,
    output logic [CHW-1:0]            out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Output stage and round-robin pointer.
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_overflow_q, out_overflow_d;
    logic [CHW-1:0]   out_channel_q, out_channel_d;
    logic             out_valid_q, out_valid_d;
    logic [CHW-1:0]   last_q, last_d;

    // Arbitration signals.
    logic [CHANNELS-1:0] req_ov;
    logic [CHANNELS-1:0] req_n;
    logic [CHANNELS-1:0] req_sel;
    logic [CHANNELS-1:0] grant;
    logic                load;
    logic                found;
    logic                grant_en;
    logic [CHW-1:0]      win;

    // The output register can take a new word when it is empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

    // Request classes: overflow records form their own class and pre-empt normal samples.
    always_comb begin
        req_ov  = enable & in_valid & in_overflow;
        req_n   = enable & in_valid & ~in_overflow;
        req_sel = (|req_ov) ? req_ov : req_n;
    end

    // Round-robin scan starting just after the last winner. The modulo keeps the scan inside
    // 0..CHANNELS-1 when CHANNELS is not a power of two.
    always_comb begin
        int unsigned idx;
        logic [CHW-1:0] idx_w;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            idx   = (32'(last_q) + k) % CHANNELS;
            idx_w = CHW'(idx);
            if (!found && req_sel[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    // No grants while reset is asserted, so no enabled source loses a word to a dropped cycle.
    assign grant_en = load && found && !rst;

    always_comb begin
        grant = '0;
        if (grant_en) begin
            grant[win] = 1'b1;
        end
    end

    // Disabled channels are always drained; their words are discarded.
    assign in_ready = grant | ~enable;

    // Next-state for the output register and pointer.
    always_comb begin
        out_data_d     = out_data_q;
        out_overflow_d = out_overflow_q;
        out_channel_d  = out_channel_q;
        out_valid_d    = out_valid_q;
        last_d         = last_q;
        if (load) begin
            if (grant_en) begin
                out_data_d     = in_data[32'(win)*WIDTH +: WIDTH];
                out_overflow_d = in_overflow[win];
                out_channel_d  = win;
                out_valid_d    = 1'b1;
                last_d         = win;
            end else begin
                // Payload fields keep their old values; only the valid flag drops.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q     <= '0;
            out_overflow_q <= 1'b0;
            out_channel_q  <= '0;
            out_valid_q    <= 1'b0;
            // Pointing at the last channel makes channel 0 the first one searched.
            last_q         <= CHW'(CHANNELS - 1);
        end else begin
            out_data_q     <= out_data_d;
            out_overflow_q <= out_overflow_d;
            out_channel_q  <= out_channel_d;
            out_valid_q    <= out_valid_d;
            last_q         <= last_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_overflow = out_overflow_q;
    assign out_channel  = out_channel_q;
    assign out_valid    = out_valid_q;

endmodule
